// File: rtl/slave_write_scheduler_if.sv
// Bundle of AW/W/B control signals between the per-slave write scheduler and the crossbar.
// "slave" modport is taken by the scheduler; "master" by whatever drives requests/handshakes.
interface slave_write_scheduler_if #(
    parameter int M                     = 2,
    parameter int NUM_OUTSTANDING_TRANS = 2
);
    localparam int MW = (M > 1) ? $clog2(M) : 1;
    localparam int CW = $clog2(NUM_OUTSTANDING_TRANS + 1);

    logic [M-1:0]  aw_req;
    logic          aw_hs;
    logic [M-1:0]  aw_grant;
    logic [MW-1:0] aw_sel;
    logic          aw_en;

    logic [M-1:0]  w_last;
    logic          w_hs;
    logic [MW-1:0] w_sel;
    logic          w_en;

    logic [MW-1:0] b_mid;
    logic          b_valid;
    logic          b_hs;
    logic [MW-1:0] b_sel;
    logic          b_en;

    logic [CW-1:0] outstanding;

    modport slave (
        input  aw_req, aw_hs, w_last, w_hs, b_mid, b_valid, b_hs,
        output aw_grant, aw_sel, aw_en, w_sel, w_en, b_sel, b_en, outstanding
    );

    modport master (
        output aw_req, aw_hs, w_last, w_hs, b_mid, b_valid, b_hs,
        input  aw_grant, aw_sel, aw_en, w_sel, w_en, b_sel, b_en, outstanding
    );
endinterface

// File: rtl/slave_write_scheduler.sv
// Per-slave AXI3 write scheduler: AW arbitration, in-order W steering, outstanding-write tracking.
// Define WSCHED_RR_EN for round-robin AW arbitration; otherwise lowest requesting index wins.
module slave_write_scheduler #(
    parameter int M                     = 2,
    parameter int NUM_OUTSTANDING_TRANS = 2
) (
    input  logic                    clk,
    input  logic                    clr,
    slave_write_scheduler_if.slave  bus
);
    localparam int MW = (M > 1) ? $clog2(M) : 1;
    localparam int CW = $clog2(NUM_OUTSTANDING_TRANS + 1);
    localparam int PW = (NUM_OUTSTANDING_TRANS > 1) ? $clog2(NUM_OUTSTANDING_TRANS) : 1;
    localparam logic [CW-1:0] N_CNT    = CW'(NUM_OUTSTANDING_TRANS);
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_OUTSTANDING_TRANS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } aw_state_t;

    aw_state_t     state, state_n;
    logic [M-1:0]  grant_q, grant_n;
    logic [MW-1:0] sel_q, sel_n;
    logic [MW-1:0] winner;
    logic          can_grant;

    logic [MW-1:0] fifo_mem [NUM_OUTSTANDING_TRANS];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] out_cnt;
    logic [MW-1:0] head;
    logic          fifo_empty, fifo_full;
    logic          aw_push, w_pop, b_dec;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

`ifdef WSCHED_RR_EN
    logic [MW-1:0] rr_ptr;

    // Search starts just after the last accepted master so every requester gets a turn.
    function automatic logic [MW-1:0] pick_winner(input logic [M-1:0] req,
                                                  input logic [MW-1:0] last);
        logic [MW-1:0] idx;
        logic          found;
        int            cand;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= M; k++) begin
            cand = (int'(last) + k) % M;
            if (!found && req[cand]) begin
                idx   = MW'(cand);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    assign winner = pick_winner(bus.aw_req, rr_ptr);

    always_ff @(posedge clk) begin
        if (clr)
            rr_ptr <= MW'(M - 1);
        else if (aw_push)
            rr_ptr <= sel_q;
    end
`else
    function automatic logic [MW-1:0] pick_winner(input logic [M-1:0] req);
        logic [MW-1:0] idx;
        idx = '0;
        for (int k = M - 1; k >= 0; k--) begin
            if (req[k])
                idx = MW'(k);
        end
        return idx;
    endfunction

    assign winner = pick_winner(bus.aw_req);
`endif

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == N_CNT);
    assign head       = fifo_mem[rd_ptr];

    // A grant needs room for both the order entry and the outstanding count.
    assign can_grant = (|bus.aw_req) && (out_cnt < N_CNT) && !fifo_full;
    assign aw_push   = (state == GRANT) && bus.aw_hs;
    assign w_pop     = !fifo_empty && bus.w_hs && bus.w_last[head];
    assign b_dec     = bus.b_hs && (out_cnt != '0);

    // ---- AW arbitration FSM ----
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
        end else begin
            state   <= state_n;
            grant_q <= grant_n;
            sel_q   <= sel_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant_q;
        sel_n   = sel_q;
        case (state)
            IDLE: begin
                if (can_grant) begin
                    grant_n         = '0;
                    grant_n[winner] = 1'b1;
                    sel_n           = winner;
                    state_n         = GRANT;
                end
            end
            GRANT: begin
                if (bus.aw_hs) begin
                    grant_n = '0;
                    sel_n   = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ---- W order FIFO ----
    always_ff @(posedge clk) begin
        if (aw_push)
            fifo_mem[wr_ptr] <= sel_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (aw_push)
                wr_ptr <= next_ptr(wr_ptr);
            if (w_pop)
                rd_ptr <= next_ptr(rd_ptr);
            case ({aw_push, w_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ---- Outstanding write counter ----
    always_ff @(posedge clk) begin
        if (clr) begin
            out_cnt <= '0;
        end else begin
            case ({aw_push, b_dec})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    assign bus.aw_grant    = grant_q;
    assign bus.aw_sel      = sel_q;
    assign bus.aw_en       = |grant_q;
    assign bus.w_en        = !fifo_empty;
    // Masked so stale storage never shows through while nothing is queued.
    assign bus.w_sel       = fifo_empty ? '0 : head;
    assign bus.b_sel       = bus.b_mid;
    assign bus.b_en        = bus.b_valid && (out_cnt != '0);
    assign bus.outstanding = out_cnt;
endmodule
